// File: rtl/elevator_pkg.sv
// elevator_pkg
//   Shared definitions for the elevator request latch / scheduler slice.
//   - FLOORS_DEF / FW_DEF : default floor count and floor index width
//   - car_state_e         : status encoding driven by car_indicator
//   - sched_state_e       : LOOK scheduler FSM states
package elevator_pkg;

   localparam int FLOORS_DEF = 5;
   localparam int FW_DEF     = 3;

   // Encoding 3 is reserved by car_indicator and is treated as idle here.
   typedef enum logic [1:0] {
      CAR_IDLE = 2'd0,
      CAR_MOVE = 2'd1,
      CAR_DOOR = 2'd2,
      CAR_RSVD = 2'd3
   } car_state_e;

   typedef enum logic [1:0] {
      SCHED_IDLE = 2'd0,
      SCHED_UP   = 2'd1,
      SCHED_DOWN = 2'd2
   } sched_state_e;

endpackage

// File: rtl/elevator_scheduler_floor_pick.sv
// floor_pick
//   Combinational nearest-pending-floor search relative to the car.
//   Ports:
//     pend      [FLOORS] in  : pending request bits, bit i = floor i
//     location  [FW]     in  : current car floor
//     dir_up             in  : 1 = search strictly above, 0 = strictly below
//     found              out : a pending floor exists in that direction
//     floor_idx [FW]     out : nearest such floor (lowest above / highest below)
module floor_pick
   import elevator_pkg::*;
#(
   parameter int FLOORS = FLOORS_DEF,
   parameter int FW     = FW_DEF
) (
   input  logic [FLOORS-1:0] pend,
   input  logic [FW-1:0]     location,
   input  logic              dir_up,
   output logic              found,
   output logic [FW-1:0]     floor_idx
);

   // Scan order is chosen so that the last match written is the nearest one:
   // descending for the upward search, ascending for the downward search.
   always_comb begin
      found     = 1'b0;
      floor_idx = '0;
      if (dir_up) begin
         for (int i = FLOORS - 1; i >= 0; i--) begin
            if (pend[i] && (i > int'(location))) begin
               found     = 1'b1;
               floor_idx = FW'(i);
            end
         end
      end else begin
         for (int i = 0; i < FLOORS; i++) begin
            if (pend[i] && (i < int'(location))) begin
               found     = 1'b1;
               floor_idx = FW'(i);
            end
         end
      end
   end

endmodule

// File: rtl/elevator_scheduler.sv
// elevator_scheduler
//   Latches car-panel and hall-call buttons as pending requests, clears a
//   request when the car's door opens at that floor, and picks the next
//   target floor with a LOOK sweep.
//   Ports:
//     clk, reset (sync, active high), enable (low = freeze everything)
//     btncar/btnout   [FLOORS] in  : car-panel / hall-call buttons (level)
//     car_state       [2]      in  : 0 idle, 1 move, 2 door, 3 = idle
//     location        [FW]     in  : current car floor
//     dest            [FW]     out : registered target floor
//     dest_valid               out : a target exists
//     dir_up                   out : sweep direction (1 = up)
//     btnidccar/btnidcout [FLOORS] out : pending request lamps
//     sched_state_dbg [2]      out : scheduler FSM state (sched_state_e)
//
//   Handshake: there is no valid/ready pair; dest is a level output that is
//   meaningful whenever dest_valid is high, and may change on any cycle.
module elevator_scheduler
   import elevator_pkg::*;
#(
   parameter int FLOORS = FLOORS_DEF,
   parameter int FW     = $clog2(FLOORS)
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              enable,
   input  logic [FLOORS-1:0] btncar,
   input  logic [FLOORS-1:0] btnout,
   input  logic [1:0]        car_state,
   input  logic [FW-1:0]     location,
   output logic [FW-1:0]     dest,
   output logic              dest_valid,
   output logic              dir_up,
   output logic [FLOORS-1:0] btnidccar,
   output logic [FLOORS-1:0] btnidcout,
   output logic [1:0]        sched_state_dbg
);

   logic [FLOORS-1:0] car_req_q, car_req_d;
   logic [FLOORS-1:0] out_req_q, out_req_d;
   sched_state_e      sched_q, sched_d;
   logic [FW-1:0]     dest_q, dest_d;
   logic              dest_valid_q, dest_valid_d;
   logic              dir_up_q, dir_up_d;

   logic [FLOORS-1:0] pend;
   logic [FLOORS-1:0] clr;
   logic              here;
   logic              moving;
   logic              up_found, dn_found;
   logic [FW-1:0]     up_floor, dn_floor;

   assign pend   = car_req_q | out_req_q;
   assign moving = (car_state == CAR_MOVE);

   // One-hot of location while the door is open; an out-of-range location
   // matches no bit, so it clears nothing.
   always_comb begin
      clr  = '0;
      here = 1'b0;
      for (int i = 0; i < FLOORS; i++) begin
         if (i == int'(location)) begin
            clr[i] = (car_state == CAR_DOOR);
            here   = pend[i];
         end
      end
   end

   floor_pick #(.FLOORS(FLOORS), .FW(FW)) u_pick_up (
      .pend      (pend),
      .location  (location),
      .dir_up    (1'b1),
      .found     (up_found),
      .floor_idx (up_floor)
   );

   floor_pick #(.FLOORS(FLOORS), .FW(FW)) u_pick_dn (
      .pend      (pend),
      .location  (location),
      .dir_up    (1'b0),
      .found     (dn_found),
      .floor_idx (dn_floor)
   );

   always_comb begin
      car_req_d    = car_req_q;
      out_req_d    = out_req_q;
      sched_d      = sched_q;
      dest_d       = dest_q;
      dest_valid_d = dest_valid_q;
      dir_up_d     = dir_up_q;

      if (enable) begin
         // Clear is applied after the OR so it wins over a press at the door.
         car_req_d = (car_req_q | btncar) & ~clr;
         out_req_d = (out_req_q | btnout) & ~clr;

         if (pend == '0) begin
            dest_valid_d = 1'b0;
            if (!moving) begin
               sched_d = SCHED_IDLE;
            end
         end else begin
            case (sched_q)
               SCHED_IDLE: begin
                  // Leaving idle sets dest in the same step so a fresh press
                  // reaches dest two cycles after the button.
                  if (here && !moving) begin
                     dest_d       = location;
                     dest_valid_d = 1'b1;
                  end else if (up_found) begin
                     sched_d      = SCHED_UP;
                     dir_up_d     = 1'b1;
                     dest_d       = up_floor;
                     dest_valid_d = 1'b1;
                  end else if (dn_found) begin
                     sched_d      = SCHED_DOWN;
                     dir_up_d     = 1'b0;
                     dest_d       = dn_floor;
                     dest_valid_d = 1'b1;
                  end
               end
               SCHED_UP: begin
                  if (up_found) begin
                     dest_valid_d = 1'b1;
                     // While travelling, only a nearer floor ahead may
                     // replace the current target.
                     if (!moving || (up_floor < dest_q)) begin
                        dest_d = up_floor;
                     end
                  end else if (!moving) begin
                     if (dn_found) begin
                        sched_d  = SCHED_DOWN;
                        dir_up_d = 1'b0;
                     end else begin
                        sched_d = SCHED_IDLE;
                     end
                  end
               end
               SCHED_DOWN: begin
                  if (dn_found) begin
                     dest_valid_d = 1'b1;
                     if (!moving || (dn_floor > dest_q)) begin
                        dest_d = dn_floor;
                     end
                  end else if (!moving) begin
                     if (up_found) begin
                        sched_d  = SCHED_UP;
                        dir_up_d = 1'b1;
                     end else begin
                        sched_d = SCHED_IDLE;
                     end
                  end
               end
               default: begin
                  sched_d = SCHED_IDLE;
               end
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         car_req_q    <= '0;
         out_req_q    <= '0;
         sched_q      <= SCHED_IDLE;
         dest_q       <= '0;
         dest_valid_q <= 1'b0;
         dir_up_q     <= 1'b1;
      end else begin
         car_req_q    <= car_req_d;
         out_req_q    <= out_req_d;
         sched_q      <= sched_d;
         dest_q       <= dest_d;
         dest_valid_q <= dest_valid_d;
         dir_up_q     <= dir_up_d;
      end
   end

   assign dest            = dest_q;
   assign dest_valid      = dest_valid_q;
   assign dir_up          = dir_up_q;
   assign btnidccar       = car_req_q;
   assign btnidcout       = out_req_q;
   assign sched_state_dbg = sched_q;

endmodule

// File: tb/tb_elevator_scheduler.sv
// tb_elevator_scheduler
//   Directed bench for elevator_scheduler: reset, latch/schedule latency,
//   retarget while moving, reversal after serving the top request, door clear
//   priority, same-floor request, enable freeze and reset with pending work.
module tb_elevator_scheduler;
   import elevator_pkg::*;

   logic       clk = 1'b0;
   logic       reset;
   logic       enable;
   logic [4:0] btncar;
   logic [4:0] btnout;
   logic [1:0] car_state;
   logic [2:0] location;
   logic [2:0] dest;
   logic       dest_valid;
   logic       dir_up;
   logic [4:0] btnidccar;
   logic [4:0] btnidcout;
   logic [1:0] sched_state_dbg;

   int checks = 0;
   int errors = 0;

   elevator_scheduler dut (
      .clk             (clk),
      .reset           (reset),
      .enable          (enable),
      .btncar          (btncar),
      .btnout          (btnout),
      .car_state       (car_state),
      .location        (location),
      .dest            (dest),
      .dest_valid      (dest_valid),
      .dir_up          (dir_up),
      .btnidccar       (btnidccar),
      .btnidcout       (btnidcout),
      .sched_state_dbg (sched_state_dbg)
   );

   // ---------------- clock ----------------
   always #5 clk = ~clk;

   // ---------------- driver helpers ----------------
   // Advance one rising edge, then settle 1 ns so checks and new drives
   // happen away from the edge.
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick();
      reset = 1'b0;
   endtask

   task automatic press_car(input logic [4:0] b);
      btncar = b;
      tick();
      btncar = '0;
   endtask

   task automatic press_out(input logic [4:0] b);
      btnout = b;
      tick();
      btnout = '0;
   endtask

   // ---------------- checker ----------------
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic chk_reset_values(input string tag);
      chk({tag, "_car_lamps"}, 32'(btnidccar), 32'h0);
      chk({tag, "_out_lamps"}, 32'(btnidcout), 32'h0);
      chk({tag, "_dest"}, 32'(dest), 32'h0);
      chk({tag, "_dest_valid"}, 32'(dest_valid), 32'h0);
      chk({tag, "_dir_up"}, 32'(dir_up), 32'h1);
      chk({tag, "_state"}, 32'(sched_state_dbg), 32'(SCHED_IDLE));
   endtask

   // ---------------- stimulus ----------------
   initial begin
      reset     = 1'b1;
      enable    = 1'b1;
      btncar    = '0;
      btnout    = '0;
      car_state = CAR_IDLE;
      location  = 3'd0;
      tick();
      tick();
      chk_reset_values("rst");
      reset = 1'b0;

      // 1: idle at 0, press car 3 -> lamp at +1, dest 3 at +2
      press_car(5'b01000);
      chk("s1_lamp", 32'(btnidccar), 32'h08);
      chk("s1_valid_early", 32'(dest_valid), 32'h0);
      tick();
      chk("s1_dest", 32'(dest), 32'd3);
      chk("s1_valid", 32'(dest_valid), 32'h1);
      chk("s1_dir", 32'(dir_up), 32'h1);
      chk("s1_state", 32'(sched_state_dbg), 32'(SCHED_UP));

      // 2: moving up toward 4 at floor 1; hall call at 1 is not a retarget,
      //    hall call at 2 is, hall call at 0 (behind) is not.
      do_reset();
      press_car(5'b10000);
      tick();
      chk("s2_dest4", 32'(dest), 32'd4);
      car_state = CAR_MOVE;
      location  = 3'd1;
      press_out(5'b00010);
      tick();
      chk("s2_here_lamp", 32'(btnidcout), 32'h02);
      chk("s2_no_retarget_here", 32'(dest), 32'd4);
      press_out(5'b00100);
      tick();
      chk("s2_retarget", 32'(dest), 32'd2);
      press_out(5'b00001);
      tick();
      chk("s2_no_retarget_behind", 32'(dest), 32'd2);
      chk("s2_state_up", 32'(sched_state_dbg), 32'(SCHED_UP));

      // 3: at floor 2 with {0,4}: up wins, serve 4, then reverse to 0
      do_reset();
      car_state = CAR_IDLE;
      location  = 3'd2;
      press_car(5'b10001);
      chk("s3_lamps", 32'(btnidccar), 32'h11);
      tick();
      chk("s3_up_priority", 32'(sched_state_dbg), 32'(SCHED_UP));
      chk("s3_dest4", 32'(dest), 32'd4);
      car_state = CAR_MOVE;
      location  = 3'd3;
      tick();
      location  = 3'd4;
      tick();
      chk("s3_no_reverse_moving", 32'(sched_state_dbg), 32'(SCHED_UP));
      car_state = CAR_DOOR;
      tick();
      chk("s3_clear4", 32'(btnidccar), 32'h01);
      chk("s3_dir_down", 32'(dir_up), 32'h0);
      chk("s3_state_down", 32'(sched_state_dbg), 32'(SCHED_DOWN));
      car_state = CAR_IDLE;
      tick();
      chk("s3_dest0", 32'(dest), 32'd0);
      chk("s3_valid", 32'(dest_valid), 32'h1);

      // 4: door open at 1 with car button 1 held -> clear wins
      do_reset();
      location  = 3'd1;
      car_state = CAR_DOOR;
      btncar    = 5'b00010;
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("s4_clear_wins", 32'(btnidccar), 32'h0);
      end
      chk("s4_no_valid", 32'(dest_valid), 32'h0);
      btncar    = '0;
      car_state = CAR_IDLE;

      // 5: idle at 2, hall call at 2 -> dest 2 staying idle; door clears it
      do_reset();
      location = 3'd2;
      press_out(5'b00100);
      chk("s5_lamp", 32'(btnidcout), 32'h04);
      tick();
      chk("s5_dest", 32'(dest), 32'd2);
      chk("s5_valid", 32'(dest_valid), 32'h1);
      chk("s5_state_idle", 32'(sched_state_dbg), 32'(SCHED_IDLE));
      car_state = CAR_DOOR;
      tick();
      chk("s5_lamp_clear", 32'(btnidcout), 32'h0);
      chk("s5_valid_hold", 32'(dest_valid), 32'h1);
      car_state = CAR_IDLE;
      tick();
      chk("s5_valid_drop", 32'(dest_valid), 32'h0);
      chk("s5_dest_hold", 32'(dest), 32'd2);

      // 6: going down from 4 to 1, then freeze for 50 cycles with pulses
      do_reset();
      location = 3'd4;
      press_car(5'b00010);
      tick();
      chk("s6_dest1", 32'(dest), 32'd1);
      chk("s6_dir_down", 32'(dir_up), 32'h0);
      enable = 1'b0;
      for (int i = 0; i < 50; i++) begin
         btncar = 5'(i % 32);
         btnout = 5'((i * 7 + 3) % 32);
         tick();
         if (i % 10 == 9) begin
            chk("s6_frz_car", 32'(btnidccar), 32'h02);
            chk("s6_frz_out", 32'(btnidcout), 32'h00);
            chk("s6_frz_dest", 32'(dest), 32'd1);
         end
      end
      btncar = '0;
      btnout = '0;
      enable = 1'b1;
      tick();
      chk("s6_lost_presses", 32'(btnidcout), 32'h00);
      chk("s6_state_kept", 32'(sched_state_dbg), 32'(SCHED_DOWN));
      press_out(5'b00100);
      chk("s6_pending_out", 32'(btnidcout), 32'h04);
      reset = 1'b1;
      tick();
      chk_reset_values("s6_rst");
      reset = 1'b0;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
